// File: rtl/mycpu_trace_capture_if.sv
// CPU bus snoop and record read-out bundle for the trace capture unit.
// The master side drives the CPU bus and consumes records; the slave side is the capture unit.
interface mycpu_trace_capture_if #(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int TSW = 16
);
    localparam int RW = 2 + TSW + AW + DW;

    logic [AW-1:0] a_out;
    logic [DW-1:0] d_out;
    logic [DW-1:0] d_in;
    logic [DW-1:0] io_in;
    logic          wen_out;
    logic          iom_out;
    logic          cpu_halt;
    logic          rd_valid;
    logic          rd_ready;
    logic [RW-1:0] rd_data;

    modport master (
        output a_out, d_out, d_in, io_in, wen_out, iom_out, cpu_halt, rd_ready,
        input  rd_valid, rd_data
    );

    modport slave (
        input  a_out, d_out, d_in, io_in, wen_out, iom_out, cpu_halt, rd_ready,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/mycpu_trace_capture.sv
// Bus trace capture: filters CPU bus cycles, timestamps them and queues them in a FIFO
// for a consumer, with optional address trigger and stop-or-overwrite on full.
module mycpu_trace_capture #(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int DEPTH        = 16,
    parameter int TSW          = 16,
    parameter int STOP_ON_FULL = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mycpu_trace_capture_if.slave   bus,
    input  logic [1:0]             mode,
    input  logic                   arm,
    input  logic                   trig_en,
    input  logic [AW-1:0]          trig_addr,
    input  logic                   clear,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [1:0]             state
);
    localparam int RW = 2 + TSW + AW + DW;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        CAPTURE = 2'b10,
        DONE    = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [TSW-1:0]  ts_q;
    logic [PW-1:0]   wrPtr_q, wrPtr_d;
    logic [PW-1:0]   rdPtr_q, rdPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [RW-1:0]   mem_q [DEPTH];

    logic [1:0]      kind;
    logic [DW-1:0]   data;
    logic            qualify;
    logic            pushReq;
    logic            full;
    logic            pop;
    logic            doWrite;
    logic            overwrite;
    logic            dropped;
    logic [RW-1:0]   record;

    // kind bit 0 is iom XOR wen, which maps the four bus cycle types onto 00/01/10/11
    always_comb begin
        kind = {bus.wen_out, bus.iom_out ^ bus.wen_out};
        if (!bus.wen_out) begin
            data = bus.d_out;
        end else if (bus.iom_out) begin
            data = bus.io_in;
        end else begin
            data = bus.d_in;
        end
        case (mode)
            2'b01:   qualify = (kind == 2'b01) || (kind == 2'b10);
            2'b10:   qualify = (kind != 2'b11);
            2'b11:   qualify = 1'b1;
            default: qualify = 1'b0;
        endcase
        record = {kind, ts_q, bus.a_out, data};
    end

    assign full = (count_q == CW'(DEPTH));
    assign pop  = (count_q != '0) && bus.rd_ready;

    always_comb begin
        state_d = state_q;
        pushReq = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (arm) begin
                    state_d = trig_en ? ARMED : CAPTURE;
                end
            end
            ARMED: begin
                if (qualify && (bus.a_out == trig_addr)) begin
                    pushReq = 1'b1;
                    state_d = CAPTURE;
                end
                if (bus.cpu_halt) begin
                    state_d = DONE;
                end
            end
            CAPTURE: begin
                pushReq = qualify;
                if (bus.cpu_halt) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pushReq && full && !pop && (STOP_ON_FULL != 0)) begin
            state_d = DONE;
        end
        if (clear) begin
            state_d = IDLE;
        end
    end

    // A simultaneous pop frees the slot, so only an unmatched push into a full buffer overflows
    always_comb begin
        dropped    = pushReq && full && !pop;
        doWrite    = pushReq && (!full || pop || (STOP_ON_FULL == 0));
        overwrite  = doWrite && full && !pop;
        wrPtr_d    = wrPtr_q + PW'(doWrite);
        rdPtr_d    = rdPtr_q + PW'(pop || overwrite);
        count_d    = count_q + CW'(doWrite && !overwrite) - CW'(pop);
        overflow_d = overflow_q || dropped;
        if (clear) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ts_q       <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_q + TSW'(1);
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doWrite && !clear) begin
            mem_q[wrPtr_q] <= record;
        end
    end

    assign bus.rd_valid = (count_q != '0);
    assign bus.rd_data  = (rst_n && (count_q != '0)) ? mem_q[rdPtr_q] : '0;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign state        = state_q;
endmodule

// File: doc/mycpu_trace_capture.md
MYCPU_TRACE_CAPTURE -- requirements
Module: mycpu_trace_capture

Interface
REQ-001 Parameter AW, default 16: bus address width.
REQ-002 Parameter DW, default 16: bus data width.
REQ-003 Parameter DEPTH, default 16: buffer entries; SHALL be a power of 2, at least 2.
REQ-004 Parameter TSW, default 16: timestamp width. Record width RW = 2+TSW+AW+DW.
REQ-005 Parameter STOP_ON_FULL, default 1: 1 = drop new records when full; 0 = overwrite oldest.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset; synchronous and active-low.
REQ-008 a_out  in  AW  CPU address bus.
REQ-009 d_out  in  DW  CPU write data.
REQ-010 d_in  in  DW  memory read data to CPU.
REQ-011 io_in  in  DW  I/O input data to CPU.
REQ-012 wen_out  in  1  CPU write enable, active-low (0 = write/OUT, 1 = read/IN).
REQ-013 iom_out  in  1  1 = I/O cycle, 0 = memory cycle.
REQ-014 cpu_halt  in  1  CPU reached HLT.
REQ-015 mode  in  2  capture filter: 00 off, 01 I/O only, 10 I/O + memory writes, 11 all cycles.
REQ-016 arm  in  1  single-cycle pulse; starts a capture session.
REQ-017 trig_en  in  1  1 = wait for address trigger; 0 = capture immediately after arm.
REQ-018 trig_addr  in  AW  trigger address.
REQ-019 clear  in  1  flushes the buffer and returns the FSM to IDLE.
REQ-020 rd_valid  out  1  head record available.
REQ-021 rd_ready  in  1  consumer accepts the head record.
REQ-022 rd_data  out  RW  head record: {kind[1:0], ts[TSW-1:0], addr[AW-1:0], data[DW-1:0]}.
REQ-023 count  out  $clog2(DEPTH)+1  number of stored records.
REQ-024 overflow  out  1  sticky; a record was dropped or overwritten.
REQ-025 state  out  2  FSM state: IDLE=00, ARMED=01, CAPTURE=10, DONE=11.

Function
REQ-026 Each cycle is classified by kind: 00 memory write (iom=0, wen=0, data=d_out); 01 I/O out (iom=1, wen=0, data=d_out); 10 I/O in (iom=1, wen=1, data=io_in); 11 memory read (iom=0, wen=1, data=d_in).
REQ-027 A cycle qualifies as follows: mode 01 for kinds 01 and 10; mode 10 for kinds 00, 01 and 10; mode 11 for all kinds; mode 00 never.
REQ-028 A free-running TSW-bit timestamp counter SHALL increment every cycle, wrap from all-ones to 0, and be unaffected by clear.
REQ-029 IDLE: an arm pulse goes to ARMED when trig_en=1, or to CAPTURE when trig_en=0; otherwise the FSM stays in IDLE.
REQ-030 ARMED: a qualifying cycle with a_out==trig_addr goes to CAPTURE, and that triggering cycle SHALL itself be recorded.
REQ-031 CAPTURE: every qualifying cycle pushes one record, which is visible at rd_data/rd_valid in the next cycle.
REQ-032 CAPTURE goes to DONE on cpu_halt; the halt cycle is recorded if it qualifies.
REQ-033 CAPTURE also goes to DONE on a push attempt while full when STOP_ON_FULL=1.
REQ-034 DONE: no further pushes; an arm pulse starts a new session without flushing the buffer.
REQ-035 cpu_halt while in ARMED SHALL go to DONE.
REQ-036 In IDLE and DONE, qualifying cycles are ignored and never set overflow.
REQ-037 Read side: rd_valid = (count != 0) and rd_data = oldest record; a pop occurs when rd_valid and rd_ready are both 1.
REQ-038 rd_data SHALL be stable while rd_valid=1 and rd_ready=0.
REQ-039 A push and a pop in the same cycle leave count unchanged, including when full; in that case there is no overflow.
REQ-040 Push while full, STOP_ON_FULL=1: the record is dropped, overflow is set, and the FSM goes to DONE.
REQ-041 Push while full, STOP_ON_FULL=0: the oldest record is discarded, the new record is appended, count stays DEPTH, and overflow is set.
REQ-042 Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-043 clear takes priority over arm, push and pop in the same cycle: count=0, overflow=0, state=IDLE.
REQ-044 arm is ignored in ARMED and CAPTURE.

Reset
REQ-045 rst_n=0 at a rising edge SHALL give state=IDLE, count=0, rd_valid=0, overflow=0, timestamp=0, and both pointers=0.
REQ-046 During reset rd_data SHALL be all zeros.
REQ-047 Reset asserted mid-capture aborts the session and discards all stored records.

Verification
REQ-048 Scenario: mode=01, trig_en=0, arm, then CPU does OUT 42 at address 5 and IN 7 at address 6 -> two records, kind 01 (addr 5, data 42) then kind 10 (addr 6, data 7), with timestamps increasing by the cycle gap.
REQ-049 Scenario: mode=10, trig_en=1, trig_addr=100, memory writes to addresses 99 then 100 then 101 -> ARMED until 100, records for 100 and 101 only.
REQ-050 Scenario: DEPTH=4, STOP_ON_FULL=1, rd_ready=0, 6 qualifying cycles -> count=4, overflow=1, state=DONE, rd_data holds the first record.
REQ-051 Scenario: DEPTH=4, STOP_ON_FULL=0, 6 qualifying cycles -> count=4, overflow=1, head = 3rd record, state=CAPTURE.
REQ-052 Scenario: full buffer with rd_ready=1 during a push -> count stays 4, overflow stays 0, records popped in order.
REQ-053 Scenario: clear asserted together with a push and a pop; separately, rst_n=0 mid-capture -> count=0, rd_valid=0, state=IDLE, and the timestamp keeps counting after clear but is 0 after reset.
